// File: rtl/counter.sv
// rtl/counter.sv - parameterised up/down counter with load, enable and registered wrap flag
module counter #(
   parameter int length = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              ld,
   input  logic              u_d,
   input  logic [length-1:0] d_in,
   output logic [length-1:0] q,
   output logic              cout
);

   localparam logic [length-1:0] MAX_VAL = '1;
   localparam logic [length-1:0] ONE     = length'(1);

   logic [length-1:0] q_q, q_d;
   logic              cout_q, cout_d;

   // Next-state: load wins over counting; the wrap flag only survives a wrapping count edge.
   always_comb begin
      q_d    = q_q;
      cout_d = 1'b0;
      if (ld) begin
         q_d = d_in;
      end else if (cen) begin
         if (u_d) begin
            q_d    = q_q + ONE;
            cout_d = (q_q == MAX_VAL);
         end else begin
            q_d    = q_q - ONE;
            cout_d = (q_q == '0);
         end
      end
   end

   // State register with synchronous reset overriding every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cout_q <= cout_d;
      end
   end

   assign q    = q_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - randomized self-checking bench for counter against an arithmetic model
module tb_counter;

   localparam int L   = 10;
   localparam int MOD = 1 << L;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cen = 1'b0;
   logic         ld  = 1'b0;
   logic         u_d = 1'b0;
   logic [L-1:0] d_in = '0;
   logic [L-1:0] q;
   logic         cout;

   int checks = 0;
   int errors = 0;
   int m_q    = 0;
   int m_cout = 0;

   counter #(.length(L)) dut (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .ld   (ld),
      .u_d  (u_d),
      .d_in (d_in),
      .q    (q),
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply inputs away from the edge, advance one rising edge, update the model, then compare.
   task automatic step(input string tag, input logic r, input logic l, input logic c,
                       input logic ud, input int din);
      @(negedge clk);
      rst  = r;
      ld   = l;
      cen  = c;
      u_d  = ud;
      d_in = din[L-1:0];
      @(posedge clk);
      if (r) begin
         m_q = 0; m_cout = 0;
      end else if (l) begin
         m_q = din % MOD; m_cout = 0;
      end else if (c && ud) begin
         m_cout = (m_q + 1 == MOD) ? 1 : 0;
         m_q    = (m_q + 1) % MOD;
      end else if (c) begin
         m_cout = (m_q == 0) ? 1 : 0;
         m_q    = (m_q + MOD - 1) % MOD;
      end else begin
         m_cout = 0;
      end
      #1;
      check({tag, ".q"}, int'(q), m_q);
      check({tag, ".cout"}, int'(cout), m_cout);
   endtask

   initial begin
      // Reset and hold
      step("reset",      1, 0, 0, 0, 0);
      check("reset_q_zero", int'(q), 0);
      step("hold0",      0, 0, 0, 0, 0);
      // Load and count up
      step("load3",      0, 1, 1, 1, 3);
      check("load3_val", int'(q), 3);
      step("up4",        0, 0, 1, 1, 0);
      step("up5",        0, 0, 1, 1, 0);
      check("up5_val", int'(q), 5);
      // Count down
      step("dn4",        0, 0, 1, 0, 0);
      step("dn3",        0, 0, 1, 0, 0);
      // Down wrap
      step("load0",      0, 1, 1, 0, 0);
      step("dnwrap",     0, 0, 1, 0, 0);
      check("dnwrap_val", int'(q), 'h3FF);
      check("dnwrap_cout", int'(cout), 1);
      step("dn3fe",      0, 0, 1, 0, 0);
      check("dn3fe_val", int'(q), 'h3FE);
      // Disable and up wrap
      step("ld3ff",      0, 1, 0, 0, 'h3FF);
      step("disabled",   0, 0, 0, 1, 7);
      check("disabled_val", int'(q), 'h3FF);
      step("upwrap",     0, 0, 1, 1, 7);
      check("upwrap_val", int'(q), 0);
      check("upwrap_cout", int'(cout), 1);
      step("afterwrap",  0, 0, 0, 1, 0);
      // Priority
      step("ld_nocen",   0, 1, 0, 1, 'h155);
      check("ld_nocen_val", int'(q), 'h155);
      step("rst_over_ld",1, 1, 1, 1, 'h2AA);
      check("rst_over_ld_val", int'(q), 0);
      step("cnt1",       0, 0, 1, 1, 0);
      step("cnt2",       0, 0, 1, 1, 0);
      step("rst_mid",    1, 0, 1, 1, 0);
      step("resume",     0, 0, 1, 1, 0);
      check("resume_val", int'(q), 1);

      // Randomized run, biased toward boundary values so both wraps occur often
      for (int i = 0; i < 3000; i++) begin
         int sel, din;
         logic r, l, c, ud;
         sel = $urandom_range(0, 3);
         din = (sel == 0) ? 0 : (sel == 1) ? MOD - 1 : (sel == 2) ? 1 : $urandom_range(0, MOD - 1);
         r   = ($urandom_range(0, 49) == 0);
         l   = ($urandom_range(0, 9) == 0);
         c   = ($urandom_range(0, 4) != 0);
         ud  = ($urandom_range(0, 3) != 0) ? u_d : ~u_d;
         step("rand", r, l, c, ud, din);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
